// File: rtl/linked_list_mqueue.sv
// Multi-queue FIFO: QUEUES logical queues kept as linked lists in one shared DEPTH-entry buffer.
// Define LLQ_FLUSH_EN to add a single-cycle whole-queue flush port.
module linked_list_mqueue #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 32,
  parameter int QUEUES = 8,
  parameter int QMAX   = DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int QW    = $clog2(QUEUES)
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef LLQ_FLUSH_EN
  input  logic                       flush,
  input  logic [QW-1:0]              flush_queue,
`endif
  input  logic                       push_valid,
  input  logic [QW-1:0]              push_queue,
  input  logic [WIDTH-1:0]           push_data,
  output logic                       push_ready,
  input  logic                       pop_valid,
  input  logic [QW-1:0]              pop_queue,
  output logic                       pop_ready,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic [QW-1:0]              rd_queue,
  output logic [QUEUES*(AW+1)-1:0]   q_count,
  output logic [AW:0]                free_count,
  output logic                       init_done
);

  typedef enum logic {INIT, RUN} state_e;

  localparam logic [AW:0] QMAX_C = (AW+1)'(QMAX);

  state_e            state_q, state_d;
  logic [AW-1:0]     init_idx_q, init_idx_d;
  logic [AW-1:0]     head_q [QUEUES];
  logic [AW-1:0]     head_d [QUEUES];
  logic [AW-1:0]     tail_q [QUEUES];
  logic [AW-1:0]     tail_d [QUEUES];
  logic [AW:0]       count_q [QUEUES];
  logic [AW:0]       count_d [QUEUES];
  logic [AW-1:0]     free_head_q, free_head_d;
  logic [AW:0]       free_count_q, free_count_d;
  logic              rd_valid_q;
  logic [WIDTH-1:0]  rd_data_q;
  logic [QW-1:0]     rd_queue_q;

  logic [WIDTH-1:0]  data_mem [DEPTH];
  logic [AW-1:0]     next_mem [DEPTH];

  logic              push_fire, pop_fire;
  logic [AW-1:0]     push_slot, push_tail, pop_head;
  logic [AW:0]       push_cnt, pop_cnt;
  logic              link_we, free_we;
  logic [AW-1:0]     link_addr, link_data, free_addr, free_data;
`ifdef LLQ_FLUSH_EN
  logic              flush_fire;
`endif

  always_comb begin
    push_ready = 1'b0;
    pop_ready  = 1'b0;
    if (state_q == RUN) begin
      push_ready = (free_count_q != '0) && (count_q[push_queue] < QMAX_C);
      pop_ready  = (count_q[pop_queue] != '0);
    end
`ifdef LLQ_FLUSH_EN
    if (flush) begin
      push_ready = 1'b0;
      pop_ready  = 1'b0;
    end
`endif
  end

  assign push_fire = push_valid & push_ready;
  assign pop_fire  = pop_valid & pop_ready;
  assign push_slot = free_head_q;
  assign push_tail = tail_q[push_queue];
  assign push_cnt  = count_q[push_queue];
  assign pop_head  = head_q[pop_queue];
  assign pop_cnt   = count_q[pop_queue];
`ifdef LLQ_FLUSH_EN
  assign flush_fire = (state_q == RUN) && flush && (count_q[flush_queue] != '0);
`endif

  // The free port is ordered after the link port so a freed entry's pointer wins on a shared address.
  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    free_head_d  = free_head_q;
    free_count_d = free_count_q;
    link_we      = 1'b0;
    link_addr    = push_tail;
    link_data    = push_slot;
    free_we      = 1'b0;
    free_addr    = pop_head;
    free_data    = free_head_q;
    if (state_q == INIT) begin
      link_we    = 1'b1;
      link_addr  = init_idx_q;
      link_data  = init_idx_q + 1'b1;
      init_idx_d = init_idx_q + 1'b1;
      if (init_idx_q == AW'(DEPTH-1)) begin
        state_d      = RUN;
        free_head_d  = '0;
        free_count_d = (AW+1)'(DEPTH);
      end
    end else begin
      if (push_fire) begin
        free_head_d         = next_mem[push_slot];
        free_count_d        = free_count_d - 1'b1;
        tail_d[push_queue]  = push_slot;
        count_d[push_queue] = count_d[push_queue] + 1'b1;
        if (push_cnt != '0) begin
          link_we = 1'b1;
        end else begin
          head_d[push_queue] = push_slot;
        end
      end
      if (pop_fire) begin
        free_we            = 1'b1;
        free_data          = free_head_d;
        free_head_d        = pop_head;
        free_count_d       = free_count_d + 1'b1;
        count_d[pop_queue] = count_d[pop_queue] - 1'b1;
        if (push_fire && (push_queue == pop_queue) && (pop_cnt == (AW+1)'(1))) begin
          head_d[pop_queue] = push_slot;
        end else begin
          head_d[pop_queue] = next_mem[pop_head];
        end
      end
`ifdef LLQ_FLUSH_EN
      if (flush_fire) begin
        link_we              = 1'b1;
        link_addr            = tail_q[flush_queue];
        link_data            = free_head_q;
        free_head_d          = head_q[flush_queue];
        free_count_d         = free_count_q + count_q[flush_queue];
        count_d[flush_queue] = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= INIT;
      init_idx_q   <= '0;
      free_head_q  <= '0;
      free_count_q <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_queue_q   <= '0;
      for (int i = 0; i < QUEUES; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      free_head_q  <= free_head_d;
      free_count_q <= free_count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      rd_valid_q   <= pop_fire;
      if (pop_fire) begin
        rd_data_q  <= data_mem[pop_head];
        rd_queue_q <= pop_queue;
      end
    end
  end

  // Buffer RAMs carry no reset; INIT rebuilds the free chain after every reset.
  always_ff @(posedge clk) begin
    if (push_fire) data_mem[push_slot] <= push_data;
    if (link_we)   next_mem[link_addr] <= link_data;
    if (free_we)   next_mem[free_addr] <= free_data;
  end

  for (genvar g = 0; g < QUEUES; g++) begin : g_qcount
    assign q_count[(g+1)*(AW+1)-1 -: AW+1] = count_q[g];
  end

  assign free_count = free_count_q;
  assign init_done  = (state_q == RUN);
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign rd_queue   = rd_queue_q;

endmodule

// File: tb/tb_linked_list_mqueue.sv
// Self-checking bench for linked_list_mqueue: per-queue reference model plus read scoreboard.
// Flush checks are compiled in when LLQ_FLUSH_EN is defined.
module tb_linked_list_mqueue;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 32;
  localparam int QUEUES = 8;
  localparam int AW     = 5;
  localparam int QW     = 3;
  localparam int S_AW   = 3;
  localparam int S_QW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                     push_valid = 1'b0;
  logic [QW-1:0]            push_queue = '0;
  logic [WIDTH-1:0]         push_data = '0;
  logic                     push_ready;
  logic                     pop_valid = 1'b0;
  logic [QW-1:0]            pop_queue = '0;
  logic                     pop_ready;
  logic                     rd_valid;
  logic [WIDTH-1:0]         rd_data;
  logic [QW-1:0]            rd_queue;
  logic [QUEUES*(AW+1)-1:0] q_count;
  logic [AW:0]              free_count;
  logic                     init_done;

  logic                     s_push_valid = 1'b0;
  logic [S_QW-1:0]          s_push_queue = '0;
  logic [WIDTH-1:0]         s_push_data = '0;
  logic                     s_push_ready;
  logic                     s_pop_valid = 1'b0;
  logic [S_QW-1:0]          s_pop_queue = '0;
  logic                     s_pop_ready;
  logic                     s_rd_valid;
  logic [WIDTH-1:0]         s_rd_data;
  logic [S_QW-1:0]          s_rd_queue;
  logic [4*(S_AW+1)-1:0]    s_q_count;
  logic [S_AW:0]            s_free_count;
  logic                     s_init_done;

`ifdef LLQ_FLUSH_EN
  logic                     flush = 1'b0;
  logic [QW-1:0]            flush_queue = '0;
  logic                     s_flush = 1'b0;
  logic [S_QW-1:0]          s_flush_queue = '0;
`endif

  linked_list_mqueue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .QUEUES(QUEUES)) dut (
    .clk(clk), .rst(rst),
`ifdef LLQ_FLUSH_EN
    .flush(flush), .flush_queue(flush_queue),
`endif
    .push_valid(push_valid), .push_queue(push_queue), .push_data(push_data), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_queue(pop_queue), .pop_ready(pop_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_queue(rd_queue),
    .q_count(q_count), .free_count(free_count), .init_done(init_done)
  );

  linked_list_mqueue #(.WIDTH(WIDTH), .DEPTH(8), .QUEUES(4), .QMAX(4)) dut_small (
    .clk(clk), .rst(rst),
`ifdef LLQ_FLUSH_EN
    .flush(s_flush), .flush_queue(s_flush_queue),
`endif
    .push_valid(s_push_valid), .push_queue(s_push_queue), .push_data(s_push_data), .push_ready(s_push_ready),
    .pop_valid(s_pop_valid), .pop_queue(s_pop_queue), .pop_ready(s_pop_ready),
    .rd_valid(s_rd_valid), .rd_data(s_rd_data), .rd_queue(s_rd_queue),
    .q_count(s_q_count), .free_count(s_free_count), .init_done(s_init_done)
  );

  logic [WIDTH-1:0]    mq [QUEUES][$];
  logic [QW+WIDTH-1:0] sb [$];
  int free_m = DEPTH;
  int tests = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] qcnt(input int q);
    return 32'(q_count[q*(AW+1) +: AW+1]);
  endfunction

  // One cycle of traffic on the main instance; the model decides acceptance and the expected read.
  task automatic applyStimulus(input logic pv, input logic [QW-1:0] pq, input logic [WIDTH-1:0] pd,
                               input logic ov, input logic [QW-1:0] oq);
    logic exp_push, exp_pop, push_acc, pop_acc;
    logic [QW+WIDTH-1:0] exp_rd;
    push_valid = pv;
    push_queue = pq;
    push_data  = pd;
    pop_valid  = ov;
    pop_queue  = oq;
    #1;
    exp_push = (free_m != 0) && (mq[pq].size() < DEPTH);
    exp_pop  = (mq[oq].size() != 0);
    if (pv) checkOutput("push_ready", 32'(push_ready), 32'(exp_push));
    if (ov) checkOutput("pop_ready", 32'(pop_ready), 32'(exp_pop));
    push_acc = pv && exp_push;
    pop_acc  = ov && exp_pop;
    if (pop_acc) begin
      sb.push_back({oq, mq[oq].pop_front()});
      free_m++;
    end
    if (push_acc) begin
      mq[pq].push_back(pd);
      free_m--;
    end
    @(negedge clk);
    push_valid = 1'b0;
    pop_valid  = 1'b0;
    checkOutput("rd_valid", 32'(rd_valid), 32'(pop_acc));
    if (pop_acc) begin
      exp_rd = sb.pop_front();
      checkOutput("rd_data", 32'(rd_data), 32'(exp_rd[WIDTH-1:0]));
      checkOutput("rd_queue", 32'(rd_queue), 32'(exp_rd[QW+WIDTH-1:WIDTH]));
    end
    checkOutput("free_count", 32'(free_count), free_m);
    checkOutput("q_count_push", qcnt(int'(pq)), mq[pq].size());
    checkOutput("q_count_pop", qcnt(int'(oq)), mq[oq].size());
  endtask

  task automatic waitInit();
    int cyc = 0;
    push_valid = 1'b1;
    pop_valid  = 1'b1;
    #1;
    checkOutput("init_push_ready", 32'(push_ready), 0);
    checkOutput("init_pop_ready", 32'(pop_ready), 0);
    push_valid = 1'b0;
    pop_valid  = 1'b0;
    while (!init_done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("init_cycles", cyc, DEPTH);
    checkOutput("init_free", 32'(free_count), DEPTH);
    checkOutput("init_qcount_zero", 32'(q_count != '0), 0);
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_init_done", 32'(init_done), 0);
    checkOutput("rst_free", 32'(free_count), 0);
    checkOutput("rst_qcount_zero", 32'(q_count != '0), 0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 0);
    checkOutput("rst_push_ready", 32'(push_ready), 0);
    checkOutput("rst_pop_ready", 32'(pop_ready), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int q = 0; q < QUEUES; q++) mq[q].delete();
    sb.delete();
    free_m = DEPTH;
    waitInit();
  endtask

  task automatic drainAll();
    for (int q = 0; q < QUEUES; q++) begin
      while (mq[q].size() != 0) applyStimulus(1'b0, '0, '0, 1'b1, QW'(q));
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    doReset();

    // Small instance with a per-queue cap of 4
    checkOutput("s_init_done", 32'(s_init_done), 1);
    for (int i = 0; i < 4; i++) begin
      s_push_valid = 1'b1;
      s_push_queue = 2'd1;
      s_push_data  = WIDTH'(8'hA0 + i);
      #1;
      checkOutput("s_push_ready", 32'(s_push_ready), 1);
      @(negedge clk);
    end
    s_push_valid = 1'b0;
    #1;
    checkOutput("s_qmax_q1", 32'(s_push_ready), 0);
    s_push_queue = 2'd0;
    #1;
    checkOutput("s_qmax_q0", 32'(s_push_ready), 1);
    checkOutput("s_qcount_q1", 32'(s_q_count[1*(S_AW+1) +: S_AW+1]), 4);
    checkOutput("s_free", 32'(s_free_count), 4);
    s_pop_valid = 1'b1;
    s_pop_queue = 2'd1;
    #1;
    checkOutput("s_pop_ready", 32'(s_pop_ready), 1);
    @(negedge clk);
    s_pop_valid  = 1'b0;
    s_push_queue = 2'd1;
    #1;
    checkOutput("s_rd_valid", 32'(s_rd_valid), 1);
    checkOutput("s_rd_data", 32'(s_rd_data), 32'hA0);
    checkOutput("s_rd_queue", 32'(s_rd_queue), 1);
    checkOutput("s_ready_after_pop", 32'(s_push_ready), 1);
    @(negedge clk);

    // Three words through queue 3
    applyStimulus(1'b1, 3'd3, 8'h11, 1'b0, 3'd0);
    applyStimulus(1'b1, 3'd3, 8'h22, 1'b0, 3'd0);
    applyStimulus(1'b1, 3'd3, 8'h33, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd3);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0);

    // Simultaneous push and pop on a single-entry queue, then pop of an empty queue
    applyStimulus(1'b1, 3'd2, 8'h55, 1'b0, 3'd0);
    applyStimulus(1'b1, 3'd2, 8'hAA, 1'b1, 3'd2);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd2);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd2);

    // Fill the whole buffer, then a pop does not make room in the same cycle
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, (i % 2 == 1) ? 3'd5 : 3'd0, WIDTH'(i + 1), 1'b0, 3'd0);
    applyStimulus(1'b1, 3'd5, 8'hEE, 1'b0, 3'd0);
    applyStimulus(1'b1, 3'd5, 8'hEF, 1'b1, 3'd0);
    applyStimulus(1'b1, 3'd5, 8'h77, 1'b0, 3'd0);
    drainAll();

    // Mixed random traffic across all queues
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), QW'($urandom_range(0, QUEUES-1)), WIDTH'($urandom),
                    1'($urandom_range(0, 1)), QW'($urandom_range(0, QUEUES-1)));
    end
    drainAll();

`ifdef LLQ_FLUSH_EN
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 3'd6, WIDTH'(8'h60 + i), 1'b0, 3'd0);
    applyStimulus(1'b1, 3'd1, 8'h91, 1'b0, 3'd0);
    applyStimulus(1'b1, 3'd1, 8'h92, 1'b0, 3'd0);
    flush       = 1'b1;
    flush_queue = 3'd6;
    push_valid  = 1'b1;
    push_queue  = 3'd0;
    pop_valid   = 1'b1;
    pop_queue   = 3'd1;
    #1;
    checkOutput("flush_push_ready", 32'(push_ready), 0);
    checkOutput("flush_pop_ready", 32'(pop_ready), 0);
    @(negedge clk);
    flush      = 1'b0;
    push_valid = 1'b0;
    pop_valid  = 1'b0;
    free_m += mq[6].size();
    mq[6].delete();
    checkOutput("flush_count", qcnt(6), 0);
    checkOutput("flush_free", 32'(free_count), free_m);
    checkOutput("flush_rd_valid", 32'(rd_valid), 0);
    for (int i = 0; i < 27; i++) applyStimulus(1'b1, QW'(i % QUEUES), WIDTH'(8'hC0 + i), 1'b0, 3'd0);
    flush       = 1'b1;
    flush_queue = 3'd6;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_nonempty_again", 32'(free_count), free_m + mq[6].size());
    free_m += mq[6].size();
    mq[6].delete();
    flush       = 1'b1;
    flush_queue = 3'd6;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_empty_noop", 32'(free_count), free_m);
    checkOutput("flush_empty_count", qcnt(6), 0);
    drainAll();
`endif

    // Reset in the middle of traffic while a read is being presented
    applyStimulus(1'b1, 3'd7, 8'h5A, 1'b0, 3'd0);
    applyStimulus(1'b1, 3'd4, 8'h6B, 1'b0, 3'd0);
    pop_valid = 1'b1;
    pop_queue = 3'd7;
    @(posedge clk);
    #1;
    pop_valid = 1'b0;
    doReset();
    applyStimulus(1'b1, 3'd4, 8'h3C, 1'b0, 3'd0);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd4);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd4);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/linked_list_mqueue.md
LINKED_LIST_MQUEUE -- requirements
Module: linked_list_mqueue

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, shared buffer entries; power of two, at least 4.
REQ-003 SHALL have parameter QUEUES, default 8, number of logical queues; at least 2.
REQ-004 SHALL have parameter QMAX, default DEPTH, per-queue occupancy cap, 1..DEPTH; derived widths are AW=log2(DEPTH) and QW=log2(QUEUES).
REQ-005 SHALL have ports: clk input 1, the single clock; rst input 1, asynchronous active-high reset.
REQ-006 SHALL have ports: push_valid in 1, push request; push_queue in QW, target queue; push_data in WIDTH, word; push_ready out 1, push accepted this cycle when high with push_valid.
REQ-007 SHALL have ports: pop_valid in 1, pop request; pop_queue in QW, source queue; pop_ready out 1, pop accepted this cycle when high with pop_valid.
REQ-008 SHALL have ports: rd_valid out 1, rd_data out WIDTH, rd_queue out QW, the popped word and its queue.
REQ-009 SHALL have ports: q_count out QUEUES*(AW+1), per-queue occupancy, queue g at bits [(g+1)*(AW+1)-1 -: AW+1]; free_count out AW+1, free entries; init_done out 1, the block is operational.

Function
REQ-010 SHALL hold all queues as singly linked lists in one shared data RAM and next-pointer RAM, with per-queue head, tail and count registers and a free list held as a head pointer plus free_count.
REQ-011 SHALL run a two-state FSM: INIT writes next[i]=i+1 for i=0..DEPTH-1, one entry per cycle; after the last write it enters RUN with free_head=0, free_count=DEPTH and init_done=1.
REQ-012 SHALL hold push_ready and pop_ready low in INIT.
REQ-013 SHALL assert push_ready combinationally in RUN iff free_count!=0 and count[push_queue]<QMAX; free entries released by a same-cycle pop SHALL NOT count toward this.
REQ-014 SHALL assert pop_ready combinationally in RUN iff count[pop_queue]!=0.
REQ-015 On an accepted push, SHALL write push_data to the free_head entry, advance free_head to next[free_head], decrement free_count, and append the entry: link it from the old tail if count!=0, otherwise set head to it; set tail to it; increment count.
REQ-016 On an accepted pop, SHALL read the head entry, set head to next[head], return the old head to the free-list front, increment free_count and decrement count.
REQ-017 SHALL present rd_valid=1 with the popped rd_data and rd_queue exactly one cycle after acceptance, and rd_valid=0 in every other cycle.
REQ-018 SHALL process a push and a pop accepted in the same cycle together, on the same or on different queues, with net count and free_count changes of zero where they cancel.
REQ-019 For a same-cycle push and pop on one queue holding count==1, SHALL return the head word and leave head=tail=the new entry, count=1.
REQ-020 SHALL NOT update any state when a request is not accepted; accepting a request when ready is low is a design error that cannot occur.

Reset
REQ-021 On rst high, SHALL immediately force: FSM to INIT, init index 0, all counts 0, free_count 0, free_head 0, rd_valid 0, init_done 0, push_ready 0, pop_ready 0.
REQ-022 SHALL restart INIT from index 0 when rst is asserted mid-INIT or mid-RUN; RAM contents are not reset and need no reset.

Configuration
REQ-023 With macro LLQ_FLUSH_EN defined, SHALL add inputs flush (1) and flush_queue (QW); in RUN, flush with count[flush_queue]!=0 splices the whole list onto the free-list front in one cycle (next[tail]=free_head, free_head=head), adds count to free_count and zeroes count.
REQ-024 With LLQ_FLUSH_EN defined, SHALL force push_ready and pop_ready low in any cycle where flush is high; a flush of an empty queue SHALL be a no-op.
REQ-025 Without LLQ_FLUSH_EN, SHALL have neither the flush ports nor the flush logic.

Verification
REQ-026 Assert rst, then release -> init_done rises exactly DEPTH cycles later (32 by default), free_count=32, all q_count=0.
REQ-027 Push 0x11, 0x22, 0x33 to queue 3, then pop queue 3 three times -> rd_data 0x11, 0x22, 0x33, each one cycle after its pop, rd_queue=3, free_count returns to 32.
REQ-028 Interleave pushes to queues 0 and 5 until free_count=0 -> push_ready=0; a same-cycle pop and push leaves push_ready low and free_count=1 in the next cycle.
REQ-029 With queue 2 at count 1, push 0xAA and pop queue 2 in the same cycle -> old word returned, count stays 1, next pop returns 0xAA; pop of an empty queue -> pop_ready=0, no rd_valid.
REQ-030 With QMAX=4, push 4 words to queue 1 -> push_ready=0 for queue 1 while still 1 for queue 0.
REQ-031 With LLQ_FLUSH_EN defined, flush queue 6 holding 5 entries -> count=0 and free_count+5 next cycle; 27 subsequent pushes all succeed; assert rst mid-stream -> outputs clear at once and INIT restarts.
